// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared widths, constants, FSM states and rounding helper for the FP adder back end
package fp_add_pkg;

   localparam int EXP_W_DEF  = 8;
   localparam int MANT_W_DEF = 28;
   localparam int BIAS       = 127;
   localparam int EXP_MAX    = 255;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      DONE
   } state_t;

   // Round-to-nearest-even increment decision.
   function automatic logic rne_inc(input logic g, input logic r, input logic s, input logic lsb);
      return g & (r | s | lsb);
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - 28-bit leading-zero counter (count of 28 for an all-zero word)
module fp_lzc (
   input  logic [27:0] data,
   output logic [4:0]  count
);

   always_comb begin
      count = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (data[i]) count = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - normalise, round-to-nearest-even and pack the add-stage vector into binary32
// FP_FAST_NORM_EN: single-cycle leading-zero shift in NORM instead of one bit per cycle.
module fp_norm_round
   import fp_add_pkg::*;
#(
   parameter int EXP_W  = EXP_W_DEF,
   parameter int MANT_W = MANT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       Ncase_in,
   input  logic              SS_in,
   input  logic [MANT_W-1:0] MS_in,
   input  logic [EXP_W-1:0]  EO_in,
   input  logic              Co_in,
   input  logic              EN_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       result,
   output logic              busy
);

   localparam int EW = EXP_W + 1;
   localparam int MW = MANT_W - 4;
`ifdef FP_FAST_NORM_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   state_t            state, state_nxt;
   logic [MANT_W-1:0] m;
   logic [EW-1:0]     e;
   logic              sign;
   logic              accept;

   assign in_ready  = reset & ((state == IDLE) | ((state == DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   state_t            d_state;
   logic [MANT_W-1:0] d_m;
   logic [EW-1:0]     d_e;
   logic [31:0]       d_result;

   always_comb begin
      d_state  = ROUND;
      d_m      = MS_in;
      d_e      = {1'b0, EO_in};
      d_result = '0;
      if (EN_in) begin
         d_state  = DONE;
         d_result = Ncase_in;
      end else if (Co_in) begin
         // Shifted-out bit folds into the sticky pair.
         d_m     = {1'b1, MS_in[MANT_W-1:2], |MS_in[1:0]};
         d_e     = {1'b0, EO_in} + EW'(1);
         d_state = FAST ? NORM : ROUND;
      end else if (MS_in == '0) begin
         d_state = DONE;
      end else if (FAST || (!MS_in[MANT_W-1] && (EO_in > EXP_W'(1)))) begin
         d_state = NORM;
      end
   end

   logic [MANT_W-1:0] norm_m;
   logic [EW-1:0]     norm_e;
   logic              norm_done;

`ifdef FP_FAST_NORM_EN
   logic [4:0]    lz;
   logic [EW-1:0] shamt;

   fp_lzc u_lzc (
      .data  (m),
      .count (lz)
   );

   // Shift is clamped so the exponent never drops below 1.
   always_comb begin
      shamt = '0;
      if (e > EW'(1)) shamt = (EW'(lz) > e - EW'(1)) ? e - EW'(1) : EW'(lz);
      norm_m    = m << shamt;
      norm_e    = e - shamt;
      norm_done = 1'b1;
   end
`else
   always_comb begin
      norm_m    = m << 1;
      norm_e    = e - EW'(1);
      norm_done = norm_m[MANT_W-1] | (norm_e <= EW'(1));
   end
`endif

   logic          inc;
   logic [MW:0]   sum;
   logic [MW-1:0] man;
   logic [EW-1:0] e_r;
   logic [31:0]   round_result;

   always_comb begin
      inc = rne_inc(m[3], m[2], |m[1:0], m[4]);
      sum = {1'b0, m[MANT_W-1:4]} + (MW+1)'(inc);
      if (sum[MW]) begin
         man = sum[MW:1];
         e_r = e + EW'(1);
      end else begin
         man = sum[MW-1:0];
         e_r = e;
      end
      // No hidden bit after rounding means a subnormal: exponent field packs 0.
      if (e_r >= EW'(EXP_MAX))
         round_result = {sign, POS_INF[30:0]};
      else
         round_result = {sign, (man[MW-1] ? e_r[EXP_W-1:0] : {EXP_W{1'b0}}), man[MW-2:0]};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = d_state;
         NORM:    if (norm_done) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE: begin
            if (accept)         state_nxt = d_state;
            else if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         m      <= '0;
         e      <= '0;
         sign   <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            m    <= d_m;
            e    <= d_e;
            sign <= SS_in;
            if (d_state == DONE) result <= d_result;
         end else if (state == NORM) begin
            m <= norm_m;
            e <= norm_e;
         end else if (state == ROUND) begin
            result <= round_result;
         end
      end
   end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - scoreboard bench for fp_norm_round with an arithmetic reference model
module tb_fp_norm_round;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, SS_in, Co_in, EN_in;
   logic        out_valid, out_ready, busy;
   logic [31:0] Ncase_in, result;
   logic [27:0] MS_in;
   logic [7:0]  EO_in;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   bit          rand_bp  = 1'b0;
   int          w, k;

`ifdef FP_FAST_NORM_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   always #5 clk = ~clk;

   fp_norm_round dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Ncase_in  (Ncase_in),
      .SS_in     (SS_in),
      .MS_in     (MS_in),
      .EO_in     (EO_in),
      .Co_in     (Co_in),
      .EN_in     (EN_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   // Value of {Co,MS} is scaled so bit 27 has biased exponent EO; round the exact value to 24 bits.
   function automatic logic [31:0] model(input logic en, input logic [31:0] nc, input logic ss,
                                         input logic [27:0] ms, input logic [7:0] eo, input logic co);
      longint      v, q, rem, half;
      int          p, t, u, eb, e0;
      logic [31:0] r;
      if (en) return nc;
      v = longint'({co, ms});
      if (v == 0) return 32'h0;
      e0 = int'(eo);
      p  = 0;
      for (int i = 0; i < 29; i++) if (v[i]) p = i;
      t = (e0 + p - 27 >= 1) ? p : 28 - e0;
      u = t - 23;
      if (u > 0) begin
         q    = v >> u;
         rem  = v - (q << u);
         half = longint'(1) << (u - 1);
         if (rem > half || (rem == half && q[0])) q++;
      end else begin
         q = v << (-u);
      end
      eb = e0 + t - 27;
      if (q == (longint'(1) << 24)) begin
         q = q >> 1;
         eb++;
      end
      if (eb >= 255) return {ss, 8'hFF, 23'h0};
      r = {ss, (q[23] ? eb[7:0] : 8'h00), q[22:0]};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, expv);
      end
   endtask

   task automatic issue(input logic en, input logic [31:0] nc, input logic ss, input logic [27:0] ms,
                        input logic [7:0] eo, input logic co, input logic [31:0] expv, output int waited);
      bit done;
      exp_q.push_back(expv);
      EN_in = en; Ncase_in = nc; SS_in = ss; MS_in = ms; EO_in = eo; Co_in = co;
      in_valid = 1'b1;
      waited = 0;
      done = 1'b0;
      while (!done && waited < 200) begin
         @(negedge clk);
         if (in_ready === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
         if (!done) waited++;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0;
      MS_in    = 28'($urandom);
      EO_in    = 8'($urandom);
      Co_in    = 1'($urandom);
      EN_in    = 1'($urandom);
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic lat_check(input string name, input int expl);
      int lat;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check(name, lat, expl);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy === 1'b1) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", n < 200, 1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out actual=0x%08h required=none", result);
            end else begin
               mon_exp = exp_q.pop_front();
               check("result", result, mon_exp);
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      Ncase_in = '0; SS_in = 1'b0; MS_in = '0; EO_in = '0; Co_in = 1'b0; EN_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      #2 reset = 1'b1;
      #1 check("idle_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      issue(0, 0, 0, 28'h0000000, 8'd127, 1, 32'h4000_0000, w);
      lat_check("lat_carry", FAST ? 3 : 2);
      issue(0, 0, 0, 28'h0000010, 8'd127, 0, 32'h3400_0000, w);
      lat_check("lat_cancel", FAST ? 3 : 25);
      issue(0, 0, 0, 28'h8000018, 8'd127, 0, 32'h3F80_0002, w);
      lat_check("lat_tie_up", FAST ? 3 : 2);
      issue(0, 0, 0, 28'h8000008, 8'd127, 0, 32'h3F80_0000, w);
      issue(1, QNAN_C(), 0, 28'h0, 8'd0, 0, 32'h7FC0_0000, w);
      lat_check("lat_special", 1);
      issue(0, 0, 0, 28'h8000000, 8'd254, 1, 32'h7F80_0000, w);
      issue(0, 0, 1, 28'h0000000, 8'd90, 0, 32'h0000_0000, w);
      lat_check("lat_zero", 1);
      issue(0, 0, 0, 28'h0000010, 8'd10, 0, 32'h0000_0200, w);
      lat_check("lat_subnormal", FAST ? 3 : 11);
      drain();

      out_ready = 1'b0;
      issue(1, 32'h1234_5678, 0, 28'h0, 8'd0, 0, 32'h1234_5678, w);
      lat_check("lat_bp", 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_result", result, 32'h1234_5678);
         check("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(1, 32'hABCD_0000, 0, 28'h0, 8'd0, 0, 32'hABCD_0000, w);
      check("reaccept_wait", w, 0);
      check("reaccept_valid", out_valid, 1);
      drain();

      EN_in = 1'b0; Co_in = 1'b0; SS_in = 1'b0; MS_in = 28'h0000010; EO_in = 8'd127;
      in_valid = 1'b1;
      @(negedge clk);
      check("mid_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (FAST ? 0 : 5) @(posedge clk);
      #1;
      check("mid_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      issue(0, 0, 0, 28'h0000010, 8'd127, 0, 32'h3400_0000, w);
      lat_check("lat_after_rst", FAST ? 3 : 25);
      drain();

      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic        en, ss, co;
         logic [31:0] nc;
         logic [27:0] ms;
         logic [7:0]  eo;
         int          kind;
         kind = $urandom_range(0, 9);
         en = 1'b0; co = 1'b0;
         nc = $urandom;
         ss = 1'($urandom);
         ms = 28'($urandom);
         eo = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(1, 255));
         case (kind)
            0:       en = 1'b1;
            1:       ms = '0;
            2, 3, 4: co = 1'b1;
            5, 6:    ms[27] = 1'b1;
            default: ms = ms >> $urandom_range(1, 27);
         endcase
         issue(en, nc, ss, ms, eo, co, model(en, nc, ss, ms, eo, co), w);
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;
      drain();
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic logic [31:0] QNAN_C();
      return 32'h7FC0_0000;
   endfunction

endmodule
